mul_arb_ctrl: RTL

Sequencing controller that shares one 4x4 shift-and-add multiplier datapath between two requesters. It arbitrates the requesters, captures operands on a valid/ready handshake and iterates one partial product per cycle. It then holds the 8-bit product on a response channel until it is accepted. It sits between the requesting FSMs and the multiplier arithmetic, so no requester needs its own array multiplier.

---
 rtl/mul_arb_pkg.sv | 19 +
 rtl/mul_arb_if.sv | 24 ++
 rtl/mul_shift_add_dp.sv | 42 ++++
 rtl/mul_arb_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared states, default width and counter sizing for mul_arb_ctrl
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF = 4;

  // Keeps the counter at least one bit wide for a degenerate W=1 build.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/mul_arb_if.sv
// rtl/mul_arb_if.sv - request/response bundle between requesters, consumer and mul_arb_ctrl
interface mul_arb_if #(parameter int W = 4);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   req_a0;
  logic [W-1:0]   req_b0;
  logic [W-1:0]   req_a1;
  logic [W-1:0]   req_b1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_data;
  logic           busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - operand registers and one-partial-product-per-step shift-and-add accumulator
module mul_shift_add_dp
  import mul_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           last
);
  localparam int CW = cnt_width(W);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] partial;

  assign partial = b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : '0;
  assign last    = (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= acc + partial;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mul_arb_ctrl.sv
// rtl/mul_arb_ctrl.sv - two-requester arbiter and IDLE/CALC/DONE sequencer around a shared shift-add multiplier
// MUL_ARB_RR_EN selects round-robin tie breaking; otherwise requester 0 has fixed priority.
module mul_arb_ctrl
  import mul_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  mul_arb_if.slave bus
);
  state_t         state;
  state_t         state_nxt;
  logic           grant;
  logic           load;
  logic           step;
  logic           last;
  logic           id;
  logic           rsp_valid_c;
  logic           busy_c;
  logic [1:0]     req_ready_c;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [2*W-1:0] acc;

`ifdef MUL_ARB_RR_EN
  logic last_grant;

  always_comb grant = (&bus.req_valid) ? ~last_grant : ~bus.req_valid[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= 1'b1;
    else if (load) last_grant <= grant;
  end
`else
  always_comb grant = ~bus.req_valid[0];
`endif

  assign a_sel = grant ? bus.req_a1 : bus.req_a0;
  assign b_sel = grant ? bus.req_b1 : bus.req_b0;

  mul_shift_add_dp #(.W(W)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a_sel),
    .b    (b_sel),
    .acc  (acc),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      id    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) id <= grant;
    end
  end

  // In IDLE the granted requester is always a valid one, so any valid implies a handshake.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    step        = 1'b0;
    req_ready_c = 2'b00;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (|bus.req_valid) begin
          req_ready_c = grant ? 2'b10 : 2'b01;
          load        = 1'b1;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.busy      = busy_c;
  assign bus.rsp_data  = (state == DONE) ? acc : '0;
  assign bus.rsp_id    = (state == DONE) & id;
endmodule
